// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave read path: tx FSM states, widths, ACK/NACK levels.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 5;
  localparam int   I2C_DATA_W = 8;
  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LOAD,
    TX_SEND,
    TX_ACK,
    TX_ACK_HOLD,
    TX_NACKED
  } tx_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Pin synchronizer with rise/fall detection; flops reset to 1 to match an idle bus.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= (sync << 1) | STAGES'(d);
      prev <= lvl;
    end
  end

  assign lvl  = sync[STAGES-1];
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

endmodule

// File: rtl/i2c_slave_tx.sv
// I2C slave read datapath: fetches RAM bytes and shifts them out on SDA until the master NACKs.
// Optional byte counter output enabled by defining I2C_SLAVE_TX_BYTECNT_EN.
module i2c_slave_tx
  import i2c_pkg::*;
#(
  parameter int ADDR_W      = I2C_ADDR_W,
  parameter int DATA_W      = I2C_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  input  logic              tx_start,
  input  logic [ADDR_W-1:0] ptr_in,
  input  logic              bus_abort,
  output logic [ADDR_W-1:0] radd,
  input  logic [DATA_W-1:0] rdata,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ptr_out
`ifdef I2C_SLAVE_TX_BYTECNT_EN
  ,
  output logic [7:0]        byte_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shreg, nxt_byte;
  logic [CNT_W-1:0]  bitcnt;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        vld_pipe;

  // index 0 = SCL, index 1 = SDA
  logic [1:0] pin, lvl, rise, fall;
  assign pin = {sda_in, scl_in};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pin[i]),
      .lvl  (lvl[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  logic scl_rise, scl_fall, sda_s;
  assign scl_rise = rise[0];
  assign scl_fall = fall[0];
  assign sda_s    = lvl[1];

  logic unused_sync;
  assign unused_sync = lvl[0] | rise[1] | fall[1];

  logic abort, start_ok, last_rise, pf_go;
  assign abort     = (state != TX_IDLE) && bus_abort;
  assign start_ok  = (state == TX_IDLE) && tx_start && !bus_abort;
  assign last_rise = scl_rise && (bitcnt == CNT_W'(DATA_W - 1));
  // Next byte is prefetched the moment the current one is fully clocked out
  assign pf_go     = (state == TX_SEND) && last_rise && !bus_abort;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = TX_IDLE;
    end else begin
      case (state)
        TX_IDLE:     if (start_ok) state_nxt = TX_FETCH;
        TX_FETCH:    state_nxt = TX_LOAD;
        TX_LOAD:     state_nxt = TX_SEND;
        TX_SEND:     if (scl_fall && bitcnt == CNT_W'(DATA_W)) state_nxt = TX_ACK;
        TX_ACK:      if (scl_rise) state_nxt = (sda_s == ACK) ? TX_ACK_HOLD : TX_NACKED;
        TX_ACK_HOLD: if (scl_fall) state_nxt = TX_SEND;
        TX_NACKED:   if (scl_fall) state_nxt = TX_IDLE;
        default:     state_nxt = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      shreg    <= '0;
      nxt_byte <= '0;
      bitcnt   <= '0;
      ptr      <= '0;
      radd     <= '0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      vld_pipe <= {vld_pipe[0], pf_go};
      if (vld_pipe[1]) nxt_byte <= rdata;
      if (abort) begin
        sda_oe <= 1'b0;
      end else begin
        case (state)
          TX_IDLE: if (start_ok) begin
            ptr  <= ptr_in;
            radd <= ptr_in;
          end
          TX_LOAD: begin
            shreg  <= rdata;
            bitcnt <= '0;
            sda_oe <= ~rdata[DATA_W-1];
          end
          TX_SEND: begin
            if (scl_rise) bitcnt <= bitcnt + CNT_W'(1);
            if (last_rise) begin
              ptr  <= ptr + ADDR_W'(1);
              radd <= ptr + ADDR_W'(1);
            end
            if (scl_fall) begin
              if (bitcnt < CNT_W'(DATA_W)) begin
                shreg  <= shreg << 1;
                sda_oe <= ~shreg[DATA_W-2];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          TX_ACK_HOLD: if (scl_fall) begin
            shreg  <= nxt_byte;
            sda_oe <= ~nxt_byte[DATA_W-1];
            bitcnt <= '0;
          end
          TX_NACKED: if (scl_fall) done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_SLAVE_TX_BYTECNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      byte_cnt <= '0;
    else if (start_ok)
      byte_cnt <= '0;
    else if (!abort && state == TX_ACK && scl_rise && sda_s == ACK && byte_cnt != 8'hFF)
      byte_cnt <= byte_cnt + 8'd1;
  end
`endif

  assign busy    = (state != TX_IDLE);
  assign ptr_out = ptr;

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Bench for i2c_slave_tx: a bus-level master reads bytes and checks them against a RAM model.
module tb_i2c_slave_tx;

  logic       clk = 1'b0, rst_n = 1'b0, scl_in = 1'b1, m_sda = 1'b1;
  logic       tx_start = 1'b0, bus_abort = 1'b0;
  logic [4:0] ptr_in = '0, radd, ptr_out;
  logic [7:0] rdata;
  logic       sda_in, sda_oe, busy, done;
`ifdef I2C_SLAVE_TX_BYTECNT_EN
  logic [7:0] byte_cnt;
`endif

  logic [7:0] mem [32];
  int n_chk = 0, n_pass = 0, n_fail = 0, done_cnt = 0, half = 250;

  // open-drain wired-AND of master and slave
  assign sda_in = m_sda & ~sda_oe;

  always #10 clk = ~clk;

  always @(posedge clk) rdata <= mem[radd];
  always @(posedge clk) if (done) done_cnt++;

  i2c_slave_tx dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .tx_start(tx_start), .ptr_in(ptr_in), .bus_abort(bus_abort),
    .radd(radd), .rdata(rdata), .sda_oe(sda_oe), .busy(busy),
    .done(done), .ptr_out(ptr_out)
`ifdef I2C_SLAVE_TX_BYTECNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Any change of sda_oe must happen while SCL is low
  logic oe_q = 1'b0, scl_q = 1'b1;
  always @(posedge clk) begin
    if (rst_n && !$isunknown(sda_oe) && sda_oe !== oe_q)
      check("sda_oe toggled with scl high", 32'(scl_q), 32'(0));
    oe_q  = sda_oe;
    scl_q = scl_in;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [4:0] p);
    ptr_in = p; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0; ptr_in = '0;
  endtask

  task automatic clk_bit(output logic b);
    tick(half); scl_in = 1'b1;
    tick(half / 2); b = sda_in;
    tick(half - half / 2); scl_in = 1'b0;
  endtask

  // Master reads nb bytes from p, ACKs all but the last
  task automatic read_xfer(input logic [4:0] p, input int nb, input bit poke);
    logic [7:0] got;
    logic       b;
    int         a;
    done_cnt = 0;
    start(p);
    if (poke) begin
      tick(3); ptr_in = 5'd20; tx_start = 1'b1;
      tick(1); tx_start = 1'b0; ptr_in = '0;
    end
    for (int i = 0; i < nb; i++) begin
      for (int k = 7; k >= 0; k--) begin clk_bit(b); got[k] = b; end
      a = (int'(p) + i) % 32;
      check($sformatf("byte%0d data", i), 32'(got), 32'(mem[a[4:0]]));
      tick(4);
      check("ack slot sda_oe", 32'(sda_oe), 32'(0));
      check("radd prefetch", 32'(radd), (int'(p) + i + 1) % 32);
      m_sda = (i == nb - 1);
      tick(half - 4); scl_in = 1'b1;
      tick(half); scl_in = 1'b0;
      tick(1); m_sda = 1'b1;
    end
    tick(4);
    check("done pulses", done_cnt, 1);
    check("busy after nack", 32'(busy), 32'(0));
    check("ptr_out after nack", 32'(ptr_out), (int'(p) + nb) % 32);
`ifdef I2C_SLAVE_TX_BYTECNT_EN
    check("byte_cnt", 32'(byte_cnt), nb - 1);
`endif
  endtask

  initial begin
    logic [4:0] p;
    logic       b;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

    tick(5);
    check("rst sda_oe", 32'(sda_oe), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst radd", 32'(radd), 32'(0));
    check("rst ptr_out", 32'(ptr_out), 32'(0));
    rst_n = 1'b1;
    tick(2); scl_in = 1'b0; tick(5);

    // two bytes at 100 kHz SCL, with a stray tx_start while busy
    half = 250;
    mem[3] = 8'hA5; mem[4] = 8'h3C;
    read_xfer(5'd3, 2, 1'b1);

    // pointer wrap 31 -> 0
    mem[31] = 8'h81; mem[0] = 8'hFE;
    read_xfer(5'd31, 2, 1'b0);

    // abort after four bits while slave pulls SDA low
    p = 5'($urandom);
    mem[p] = 8'($urandom) & 8'hF7;
    done_cnt = 0;
    start(p);
    for (int k = 0; k < 4; k++) clk_bit(b);
    tick(4);
    check("oe before abort", 32'(sda_oe), 32'(1));
    bus_abort = 1'b1; tick(1); bus_abort = 1'b0;
    check("abort sda_oe", 32'(sda_oe), 32'(0));
    check("abort busy", 32'(busy), 32'(0));
    check("abort ptr_out", 32'(ptr_out), 32'(p));
    tick(20);
    check("abort no done", done_cnt, 0);

    // abort and start in the same clock: abort wins
    bus_abort = 1'b1; tx_start = 1'b1; ptr_in = p + 5'd7;
    tick(1); bus_abort = 1'b0; tx_start = 1'b0; ptr_in = '0;
    tick(2);
    check("abort+start busy", 32'(busy), 32'(0));
    check("abort+start ptr_out", 32'(ptr_out), 32'(p));

    // reset mid-byte while driving low
    p = 5'($urandom);
    mem[p] = 8'($urandom) & 8'hDF;
    start(p);
    clk_bit(b); clk_bit(b);
    tick(4);
    check("oe before reset", 32'(sda_oe), 32'(1));
    rst_n = 1'b0; tick(1);
    check("reset sda_oe", 32'(sda_oe), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset ptr_out", 32'(ptr_out), 32'(0));
    rst_n = 1'b1; tick(6);

    // randomized start pointers and RAM contents, 1..4 bytes, faster SCL
    half = 20;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      read_xfer(5'($urandom), k + 1, 1'b0);
      tick(10);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx.md
Name: i2c_slave_tx

Overview:
- Read-direction datapath of the I2C slave; the counterpart of the write path that fills the 32x8 register RAM.
- After the slave controller has ACKed an address byte with R/W=1, this block fetches bytes from the RAM read port and shifts them out on SDA, MSB first.
- Samples the master's ACK/NACK after each byte; auto-increments the read pointer until the master NACKs or the bus is aborted.

Parameters:
ADDR_W, 5, RAM address width; pointer wraps modulo 2^ADDR_W
DATA_W, 8, byte width; fixed at 8 for I2C, kept parametric for the shift counter
SYNC_STAGES, 2, flop stages on scl_in and sda_in before edge detection

Ports:
clk  in  1  system clock, >=10x SCL rate
rst_n  in  1  synchronous active-low reset
scl_in  in  1  raw SCL pin level
sda_in  in  1  raw SDA pin level
tx_start  in  1  one-clk pulse; SCL already low after the address-ACK falling edge
ptr_in  in  ADDR_W  start address, captured on tx_start
bus_abort  in  1  START/STOP detected by the slave controller
radd  out  ADDR_W  RAM read address
rdata  in  DATA_W  RAM read data, valid 1 clk after radd is presented
sda_oe  out  1  1 = pull SDA low (open drain), 0 = release
busy  out  1  high from tx_start until return to IDLE
done  out  1  one-clk pulse when master NACK ends the transfer
ptr_out  out  ADDR_W  pointer to the next unsent byte (for the write path / next read)

Behaviour:
- Clock and reset: all state on posedge clk. rst_n=0 (sync) forces IDLE; sda_oe=0, busy=0, done=0, radd=0, ptr=0, shift register=0, bit count=0, sync flops=1 (idle bus).
- Edge detection: scl_s/sda_s come from SYNC_STAGES flops. scl_rise = scl_s & ~scl_prev; scl_fall = ~scl_s & scl_prev.
- IDLE: sda_oe=0. On tx_start: ptr<=ptr_in, radd<=ptr_in, go to FETCH.
- FETCH (1 clk, waits out RAM latency) -> LOAD.
- LOAD: shreg<=rdata, bitcnt<=0, sda_oe<=~rdata[7] -> SEND. First bit is driven 2 clk after tx_start.
- SEND:
  - On scl_rise: bitcnt++.
  - On scl_fall with bitcnt<8: shift left, sda_oe<=~shreg[6].
  - When bitcnt reaches 8: ptr<=ptr+1 (wraps 31->0) and radd<=ptr+1 (prefetch); next byte latched in nxt_byte 1 clk later.
  - On scl_fall with bitcnt==8: sda_oe<=0 -> ACK.
- ACK: sample sda_s on scl_rise. 0 -> ACK_HOLD. 1 -> NACKED.
- ACK_HOLD: on scl_fall, load shreg<=nxt_byte, sda_oe<=~nxt_byte[7], bitcnt<=0 -> SEND. No clock stretching needed.
- NACKED: on scl_fall, done pulse for 1 clk -> IDLE.
  - ptr_out = address after the last sent byte; the NACKed byte still counts as sent.
- SDA changes only 1 clk after a detected scl_fall, never while SCL is high.
- bus_abort in any non-IDLE state: next clk IDLE, sda_oe=0, no done pulse. ptr keeps its current value.
- Simultaneous events:
  - tx_start while busy: ignored.
  - bus_abort and tx_start in the same clk: abort wins.
  - rst_n low overrides everything.
- busy=1 in every state except IDLE.

Optional Feature:
I2C_SLAVE_TX_BYTECNT_EN
- Defined: adds output byte_cnt[7:0]. Cleared on tx_start, +1 per ACKed byte, saturates at 255. Reset value 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package (i2c_pkg): tx state enum (IDLE, FETCH, LOAD, SEND, ACK, ACK_HOLD, NACKED), I2C_ADDR_W=5, I2C_DATA_W=8, ACK=1'b0 / NACK=1'b1 constants.
- One natural sub-module: i2c_sync_edge. Instantiated twice (SCL, SDA); outputs synchronized level, rise, fall.

Test Plan:
- RAM[3]=8'hA5, RAM[4]=8'h3C. tx_start with ptr_in=3, master clocks 2 bytes, ACKs the first and NACKs the second -> SDA bits 10100101 then 00111100, sda_oe=0 in both ACK slots, done pulse once, ptr_out=5, busy falls.
- ptr_in=31, RAM[31]=8'h81, RAM[0]=8'hFE, ACK then NACK -> bytes 81, FE sent; radd wraps 31->0; ptr_out=1.
- Clock the master at 100 kHz with clk=50 MHz -> sda_oe never toggles while scl_in=1 (checker asserted throughout).
- bus_abort mid-byte after 4 bits -> sda_oe=0 next clk, IDLE, no done pulse, ptr_out unchanged.
- rst_n=0 mid-SEND while sda_oe=1 -> next clk sda_oe=0, busy=0, ptr_out=0.
- With I2C_SLAVE_TX_BYTECNT_EN defined: 3 ACKed bytes + 1 NACKed byte -> byte_cnt=3.
